// File: rtl/song_pkg.sv
// Shared types, constants and song contents for the song sequencer.
package song_pkg;

  localparam int SONG_HP_W = 15;
  localparam int SONG_LEN  = 4;

  localparam logic [SONG_HP_W-1:0] REST_HP = '0;
  localparam logic [7:0]           END_DUR = '0;

  typedef struct packed {
    logic [SONG_HP_W-1:0] half_period;
    logic [7:0]           duration;
  } note_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  localparam note_t SONG [SONG_LEN] = '{
    '{half_period: 15'd28408, duration: 8'd2},
    '{half_period: 15'd0,     duration: 8'd1},
    '{half_period: 15'd20408, duration: 8'd3},
    '{half_period: 15'd0,     duration: 8'd0}
  };

  // Entries past the stored song read back as end markers.
  function automatic note_t song_entry(input int i);
    song_entry = '{half_period: REST_HP, duration: END_DUR};
    for (int k = 0; k < SONG_LEN; k++) begin
      if (k == i) song_entry = SONG[k];
    end
  endfunction

endpackage

// File: rtl/note_rom.sv
// Synchronous-read note table built from the song in song_pkg.
module note_rom
  import song_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  output note_t            data
);

  always_ff @(posedge clk) begin
    data <= song_entry(int'(addr));
  end

endmodule

// File: rtl/song_sequencer.sv
// Steps through the note table, driving half-period and enable for an
// external square-wave tone generator, with start/stop/loop control.
module song_sequencer
  import song_pkg::*;
#(
  parameter  int NOTE_COUNT = 32,
  parameter  int TICK_DIV   = 1_250_000,
  parameter  int GAP_TICKS  = 2,
  parameter  int HP_W       = 15,
  localparam int IDX_W      = $clog2(NOTE_COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic [HP_W-1:0]  note_value,
  output logic             tone_en,
  output logic [IDX_W-1:0] note_index,
  output logic             busy,
  output logic             done
);

  localparam int               TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NOTE_COUNT - 1);
  localparam logic [7:0]        GAP_DUR   = 8'(GAP_TICKS);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [7:0]        dur_q, dur_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              ton_q, ton_d;
  logic              tick, seg_end, next_note, end_song;
  note_t             rom_q;

  // The ROM is addressed with the next index so its registered output is
  // already valid during the single LOAD cycle.
  note_rom #(.IDX_W(IDX_W)) u_rom (
    .clk  (clk),
    .addr (idx_d),
    .data (rom_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      hp_q    <= '0;
      ton_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      hp_q    <= hp_d;
      ton_q   <= ton_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tick_d    = tick_q;
    dur_d     = dur_q;
    hp_d      = hp_q;
    ton_d     = ton_q;
    tick      = (tick_q == TICK_LAST);
    seg_end   = tick && (dur_q == 8'd1);
    next_note = 1'b0;
    end_song  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (rom_q.duration == END_DUR) begin
          end_song = 1'b1;
        end else begin
          state_d = S_PLAY;
          tick_d  = '0;
          dur_d   = rom_q.duration;
          hp_d    = HP_W'(rom_q.half_period);
          ton_d   = (rom_q.half_period != REST_HP);
        end
      end
      S_PLAY: begin
        tick_d = tick ? '0 : tick_q + TICK_W'(1);
        if (tick) dur_d = dur_q - 8'd1;
        if (seg_end) begin
          hp_d  = '0;
          ton_d = 1'b0;
          if (GAP_TICKS == 0) begin
            next_note = 1'b1;
          end else begin
            state_d = S_GAP;
            tick_d  = '0;
            dur_d   = GAP_DUR;
          end
        end
      end
      S_GAP: begin
        tick_d = tick ? '0 : tick_q + TICK_W'(1);
        if (tick) dur_d = dur_q - 8'd1;
        if (seg_end) next_note = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (next_note) begin
      if (idx_q == LAST_IDX) begin
        end_song = 1'b1;
      end else begin
        state_d = S_LOAD;
        idx_d   = idx_q + IDX_W'(1);
      end
    end

    if (end_song) begin
      if (loop) begin
        state_d = S_LOAD;
        idx_d   = '0;
      end else begin
        state_d = S_DONE;
      end
    end

    // Abort wins over everything else and leaves no done pulse behind.
    if (stop) begin
      state_d = S_IDLE;
      idx_d   = '0;
      tick_d  = '0;
      dur_d   = '0;
      hp_d    = '0;
      ton_d   = 1'b0;
    end
  end

  assign note_value = hp_q;
  assign tone_en    = ton_q;
  assign note_index = idx_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_PLAY) || (state_q == S_GAP);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed vector bench for song_sequencer with TICK_DIV=4, GAP_TICKS=1 and
// the four-entry test song.
module tb_song_sequencer;

  typedef struct {
    logic        start;
    logic        stop;
    logic        loop;
    int          cycles;
    logic [14:0] hp;
    logic        ton;
    logic [1:0]  idx;
    logic        busy;
    logic        done;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [14:0] note_value;
  logic        tone_en;
  logic [1:0]  note_index;
  logic        busy;
  logic        done;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];

  song_sequencer #(
    .NOTE_COUNT (4),
    .TICK_DIV   (4),
    .GAP_TICKS  (1),
    .HP_W       (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .note_value (note_value),
    .tone_en    (tone_en),
    .note_index (note_index),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic s, input logic sp, input logic lp, input int n,
                              input int hp, input logic t, input int idx,
                              input logic b, input logic d);
    vec_t v;
    v.start = s; v.stop = sp; v.loop = lp; v.cycles = n;
    v.hp = 15'(hp); v.ton = t; v.idx = 2'(idx); v.busy = b; v.done = d;
    vecs.push_back(v);
  endfunction

  // Entries 0..2 plus the end-marker LOAD, following the first LOAD cycle.
  function automatic void add_song(input logic s, input logic lp);
    add(s, 0, lp, 8,  28408, 1, 0, 1, 0);
    add(s, 0, lp, 4,  0,     0, 0, 1, 0);
    add(s, 0, lp, 9,  0,     0, 1, 1, 0);
    add(s, 0, lp, 1,  0,     0, 2, 1, 0);
    add(s, 0, lp, 12, 20408, 1, 2, 1, 0);
    add(s, 0, lp, 4,  0,     0, 2, 1, 0);
    add(s, 0, lp, 1,  0,     0, 3, 1, 0);
  endfunction

  task automatic check_output(input string name, input logic [14:0] hp, input logic ton,
                              input logic [1:0] idx, input logic bsy, input logic dn);
    n_cmp++;
    if (note_value !== hp || tone_en !== ton || note_index !== idx || busy !== bsy || done !== dn) begin
      n_err++;
      $display("[TB] FAIL %s: got value=%0d en=%b idx=%0d busy=%b done=%b, want value=%0d en=%b idx=%0d busy=%b done=%b",
               name, note_value, tone_en, note_index, busy, done, hp, ton, idx, bsy, dn);
    end
  endtask

  task automatic apply_stimulus(input int r);
    start = vecs[r].start;
    stop  = vecs[r].stop;
    loop  = vecs[r].loop;
    for (int c = 0; c < vecs[r].cycles; c++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("row%0d/cyc%0d", r, c), vecs[r].hp, vecs[r].ton,
                   vecs[r].idx, vecs[r].busy, vecs[r].done);
    end
  endtask

  initial begin
    int n;

    // idle after reset
    add(0, 0, 0, 20, 0, 0, 0, 0, 0);
    // plain run to done
    add(1, 0, 0, 1, 0, 0, 0, 1, 0);
    add_song(0, 0);
    add(0, 0, 0, 1, 0, 0, 3, 0, 1);
    add(0, 0, 0, 3, 0, 0, 0, 0, 0);
    // looping run, then stop mid-gap
    add(1, 0, 1, 1, 0, 0, 0, 1, 0);
    add_song(0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 8, 28408, 1, 0, 1, 0);
    add(0, 0, 1, 2, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 3, 0, 0, 0, 0, 0);
    // stop in the 5th PLAY cycle of entry 0
    add(1, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 4, 28408, 1, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 5, 0, 0, 0, 0, 0);
    // start and stop together while idle
    add(1, 1, 0, 3, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // start pulse while busy has no effect
    add(1, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 3, 28408, 1, 0, 1, 0);
    add(1, 0, 0, 1, 28408, 1, 0, 1, 0);
    add(0, 0, 0, 4, 28408, 1, 0, 1, 0);
    add(0, 0, 0, 4, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    // start held high across DONE retriggers
    add(1, 0, 0, 1, 0, 0, 0, 1, 0);
    add_song(1, 0);
    add(1, 0, 0, 1, 0, 0, 3, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 2, 28408, 1, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);

    #2;
    check_output("reset_state", 15'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    for (int r = 0; r < vecs.size(); r++) apply_stimulus(r);

    // done latency: start sampled at one edge, done seen after edge +40
    stop  = 1'b0;
    loop  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (n != 40) begin
      n_err++;
      $display("[TB] FAIL done_latency: got %0d edges, want 40", n);
    end
    @(posedge clk);
    #1;

    // asynchronous reset during the gap of entry 0
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_output("pre_reset_gap", 15'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1;
    check_output("async_reset", 15'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("post_reset_idle", 15'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("restart_load", 15'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_output("restart_play", 15'd28408, 1'b1, 2'd0, 1'b1, 1'b0);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check_output("final_stop", 15'd0, 1'b0, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Plays a fixed melody by stepping through a note table and driving one square-wave tone generator. For each entry it presents a half-period value and a tone enable for a set duration, then inserts a silent articulation gap. It supports start, stop and loop control. It replaces hard-wired constant half-periods at the top level with a sequenced song.

## Interface
Parameters:
- `NOTE_COUNT`, default 32: number of note-table entries.
- `TICK_DIV`, default 1_250_000: clk cycles per duration tick (10 ms at 125 MHz).
- `GAP_TICKS`, default 2: silent ticks after every note.
- `HP_W`, default 15: half-period width; must match the tone generator's `value` input.

Ports:
- `clk`  in  1  system clock. One clock only; all logic is on `posedge clk`.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level, sampled each cycle; begins playback from entry 0 when idle.
- `stop`  in  1  aborts playback; takes priority over `start`.
- `loop`  in  1  when high at end of song, restart from entry 0 instead of finishing.
- `note_value`  out  HP_W  half-period to the tone generator; 0 when not playing.
- `tone_en`  out  1  tone generator enable.
- `note_index`  out  $clog2(NOTE_COUNT)  current table entry.
- `busy`  out  1  high in LOAD, PLAY and GAP.
- `done`  out  1  one-cycle pulse at natural end of song.

## Operation
- Table entry format: `{half_period[HP_W-1:0], duration[7:0]}`. Duration is in ticks.
  - `half_period` = 0 means rest: PLAY runs but `tone_en` stays 0.
  - `duration` = 0 means end marker.
- FSM states:
  - IDLE: `start` && !`stop` → LOAD, with index=0.
  - LOAD (1 cycle): ROM output registered.
    - duration≠0 → PLAY, latching `note_value` and `tone_en` = (hp≠0).
    - duration=0 → end handling.
  - PLAY: runs for duration×TICK_DIV cycles, then → GAP with `tone_en`=0 and `note_value`=0.
  - GAP: runs for GAP_TICKS×TICK_DIV cycles.
    - If index = NOTE_COUNT-1 → end handling.
    - Otherwise index+1 → LOAD.
  - End handling:
    - `loop`=1 → index=0, LOAD.
    - Otherwise → DONE.
  - DONE (1 cycle): `done`=1, then → IDLE.
- Tick prescaler: a TICK_DIV-modulus counter, cleared on every entry to PLAY or GAP.
- Duration counter: 8-bit down-counter, decremented on each tick wrap.
- `stop` in any state → IDLE on the next edge. At that edge `tone_en`, `note_value` and `busy` go to 0, index goes to 0, and no `done` pulse is issued.
- `start` while `busy` is ignored. `start` held high across DONE retriggers from IDLE on the following cycle.
- GAP_TICKS=0: GAP lasts 0 cycles, so PLAY goes directly to LOAD or end handling.
- `loop` is sampled only at end handling.

## Timing
- Reset values: `note_value`=0, `tone_en`=0, `note_index`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- Startup: `start` sampled at edge N → LOAD after edge N. PLAY outputs are valid after edge N+1 (1-cycle start latency).
- Cycles per note: 1 (LOAD) + duration×TICK_DIV (PLAY) + GAP_TICKS×TICK_DIV (GAP).
- End marker: LOAD → DONE on the next edge. `done` is high for exactly one cycle, and `busy` is low during DONE.
- Reset asserted mid-playback: all outputs return to reset values immediately (asynchronous).

## Structure
- Shared package `song_pkg` holds:
  - `note_t` struct (half_period, duration);
  - `REST_HP`=0 and `END_DUR`=0;
  - the FSM state enum;
  - the song contents as a `note_t` constant array.
- Sub-module `note_rom`: synchronous-read ROM indexed by `note_index`, initialized from `song_pkg`.
- The tone generator stays external. The top level connects `note_value` and `tone_en` to it.

## Test plan
All scenarios use TICK_DIV=4, GAP_TICKS=1 and this table: {28408,2}, {0,1}, {20408,3}, {0,0}.

- Reset, then idle 20 cycles → all outputs 0, `busy`=0.
- `start` pulsed at edge 0:
  - `note_value`=28408, `tone_en`=1 for cycles 2–9;
  - gap cycles 10–13 with `tone_en`=0;
  - rest entry: `tone_en`=0, index=1 for 4 cycles;
  - `note_value`=20408 for 12 cycles;
  - then `done` pulse, `busy`=0.
- Same run with `loop`=1 → after entry 2's gap, index returns to 0 and 28408 replays; `done` is never asserted.
- `stop` asserted in the 5th PLAY cycle of entry 0 → next edge: `tone_en`=0, `busy`=0, index=0, no `done`.
- `start` and `stop` high in the same cycle while idle → stays IDLE. `start` pulsed while busy → no restart, timing unchanged.
- `reset` asserted mid-GAP → all outputs 0 immediately. A subsequent `start` plays from entry 0 with the normal 1-cycle latency.
